// File: rtl/if_fetch_unit.sv
// Instruction-fetch engine: request/response imem port, in-order prefetch queue, redirect flush.
// Optional macro IF_MISALIGN_CHK_EN: a misaligned redirect halts fetch and presents one flagged entry.
module if_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_src,
    input  logic [XLEN-1:0] new_pc,
    input  logic            stall_if,
    input  logic            bubble_if,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic [XLEN-1:0] out_instr,
    output logic            out_misalign
);
    localparam int unsigned     AW        = $clog2(QDEPTH);
    localparam int unsigned     CW        = AW + 1;
    localparam logic [CW:0]     LP_QDEPTH = QDEPTH[CW:0];
    localparam logic [XLEN-1:0] LP_NOP    = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_a_pc [QDEPTH];
    logic [AW-1:0]   r_a_head;
    logic [AW-1:0]   r_a_tail;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop;
    logic [XLEN-1:0] r_q_pc [QDEPTH];
    logic [XLEN-1:0] r_q_instr [QDEPTH];
    logic [AW-1:0]   r_q_head;
    logic [AW-1:0]   r_q_tail;
    logic [CW-1:0]   r_q_count;
    logic [XLEN-1:0] r_last_pc;
    logic [XLEN-1:0] r_last_instr;

    logic            w_accept;
    logic            w_resp;
    logic            w_drop_hit;
    logic            w_push_mem;
    logic            w_mis_push;
    logic            w_push;
    logic            w_pop;
    logic            w_halted;
    logic            w_q_nonempty;
    logic [CW:0]     w_occ;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_push_pc;
    logic [XLEN-1:0] w_push_instr;

`ifdef IF_MISALIGN_CHK_EN
    logic            r_halted;
    logic            r_mis_pend;
    logic [XLEN-1:0] r_mis_pc;
    logic            r_q_mis [QDEPTH];
    logic            r_last_mis;

    assign w_target   = new_pc;
    assign w_halted   = r_halted;
    assign w_mis_push = r_mis_pend && (r_drop == '0) && !pc_src;

    // The flagged entry waits until every stale response has drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted   <= 1'b0;
            r_mis_pend <= 1'b0;
            r_mis_pc   <= '0;
        end else if (pc_src) begin
            r_halted   <= (new_pc[1:0] != 2'b00);
            r_mis_pend <= (new_pc[1:0] != 2'b00);
            r_mis_pc   <= new_pc;
        end else if (w_mis_push) begin
            r_mis_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_q_mis[r_q_tail] <= w_mis_push;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_mis <= 1'b0;
        end else if (w_q_nonempty) begin
            r_last_mis <= r_q_mis[r_q_head];
        end
    end

    assign out_misalign = w_q_nonempty ? r_q_mis[r_q_head] : r_last_mis;
    assign w_push_pc    = w_mis_push ? r_mis_pc : r_a_pc[r_a_head];
    assign w_push_instr = w_mis_push ? LP_NOP : imem_resp_data;
`else
    assign w_target     = new_pc & ~XLEN'(3);
    assign w_halted     = 1'b0;
    assign w_mis_push   = 1'b0;
    assign out_misalign = 1'b0;
    assign w_push_pc    = r_a_pc[r_a_head];
    assign w_push_instr = imem_resp_data;
`endif

    assign w_occ          = {1'b0, r_q_count} + {1'b0, r_inflight};
    assign imem_req_valid = !rst && !pc_src && (w_occ < LP_QDEPTH) && !w_halted;
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is ignored so the counters cannot underflow.
    assign w_resp       = imem_resp_valid && (r_inflight != '0);
    assign w_drop_hit   = w_resp && (r_drop != '0);
    assign w_push_mem   = w_resp && (r_drop == '0) && !pc_src;
    assign w_push       = w_push_mem || w_mis_push;
    assign w_q_nonempty = (r_q_count != '0);
    assign out_valid    = w_q_nonempty && !bubble_if;
    assign w_pop        = out_valid && !stall_if && !pc_src;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_a_head   <= '0;
            r_a_tail   <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            r_q_head   <= '0;
            r_q_tail   <= '0;
            r_q_count  <= '0;
        end else begin
            if (pc_src) begin
                r_fetch_pc <= w_target;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            if (w_accept) begin
                r_a_tail <= r_a_tail + AW'(1);
            end
            if (w_resp) begin
                r_a_head <= r_a_head + AW'(1);
            end
            r_inflight <= r_inflight + CW'(w_accept) - CW'(w_resp);
            // Nothing issues during a redirect, so what remains outstanding must all be dropped.
            if (pc_src) begin
                r_drop <= r_inflight - CW'(w_resp);
            end else if (w_drop_hit) begin
                r_drop <= r_drop - CW'(1);
            end
            if (pc_src) begin
                r_q_head  <= '0;
                r_q_tail  <= '0;
                r_q_count <= '0;
            end else begin
                if (w_push) begin
                    r_q_tail <= r_q_tail + AW'(1);
                end
                if (w_pop) begin
                    r_q_head <= r_q_head + AW'(1);
                end
                r_q_count <= r_q_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a_pc[r_a_tail] <= r_fetch_pc;
        end
        if (!rst && w_push) begin
            r_q_pc[r_q_tail]    <= w_push_pc;
            r_q_instr[r_q_tail] <= w_push_instr;
        end
    end

    // Shadow of the head so the data outputs hold their last values when the queue drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_pc    <= RESET_PC;
            r_last_instr <= LP_NOP;
        end else if (w_q_nonempty) begin
            r_last_pc    <= r_q_pc[r_q_head];
            r_last_instr <= r_q_instr[r_q_head];
        end
    end

    assign out_pc       = w_q_nonempty ? r_q_pc[r_q_head] : r_last_pc;
    assign out_instr    = w_q_nonempty ? r_q_instr[r_q_head] : r_last_instr;
    assign out_pc_plus4 = out_pc + XLEN'(4);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory model with configurable latency and
// an expected-PC scoreboard consumed on every instruction accepted by decode.
module tb_if_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_src = 1'b0;
    logic [31:0] new_pc = '0;
    logic        stall_if = 1'b0;
    logic        bubble_if = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;
    logic        out_misalign;

    if_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .QDEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc_src(pc_src), .new_pc(new_pc),
        .stall_if(stall_if), .bubble_if(bubble_if),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .out_valid(out_valid), .out_pc(out_pc),
        .out_pc_plus4(out_pc_plus4), .out_instr(out_instr), .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: in-order responses, each due no earlier than its latency.
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          last_due = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          rdy_rand = 1'b0;
    bit          sb_en = 1'b1;
    logic [31:0] exp_q[$];
    logic [31:0] exp_next = RESET_PC;
    int          n_pops = 0;

    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_out_valid;
    logic [31:0] s_out_pc;
    logic [31:0] s_out_pc4;
    logic [31:0] s_out_instr;
    logic        s_out_mis;

    task automatic fill_exp();
        while (exp_q.size() < 4) begin
            exp_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
        end
    endtask

    task automatic cycle();
        logic [31:0] e;
        int          d;
        if (rst) begin
            mq_addr.delete();
            mq_due.delete();
            last_due = 0;
            imem_resp_valid = 1'b0;
        end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mq_addr.pop_front() ^ KEY;
            void'(mq_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_out_valid = out_valid;
        s_out_pc    = out_pc;
        s_out_pc4   = out_pc_plus4;
        s_out_instr = out_instr;
        s_out_mis   = out_misalign;
        if (!rst) begin
            if (imem_req_valid && imem_req_ready) begin
                d = cyc + ((lat == 0) ? int'($urandom_range(1, 3)) : lat);
                if (d < last_due) d = last_due;
                last_due = d;
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(d);
            end
            if (pc_src) begin
                exp_q.delete();
                exp_next = new_pc & ~32'h3;
                fill_exp();
            end else if (sb_en && s_out_valid && !stall_if) begin
                fill_exp();
                e = exp_q.pop_front();
                check("pop_pc", s_out_pc, e);
                check("pop_pc4", s_out_pc4, e + 32'd4);
                check("pop_instr", s_out_instr, e ^ KEY);
                check("pop_mis", {31'b0, s_out_mis}, 32'd0);
                n_pops++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_first(input string tag, input logic [31:0] exp_pc);
        int seen;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (s_out_valid) begin
                check(tag, s_out_pc, exp_pc);
                seen = 1;
                break;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int first;
        int nv;
        int p0;
        logic [31:0] bexp;
`ifdef IF_MISALIGN_CHK_EN
        int seen;
        int req_seen;
`endif

        // Reset values
        rst = 1'b1;
        repeat (3) cycle();
        check("rst_req_valid", {31'b0, s_req_valid}, 32'd0);
        check("rst_out_valid", {31'b0, s_out_valid}, 32'd0);
        check("rst_out_pc", s_out_pc, RESET_PC);
        check("rst_out_pc4", s_out_pc4, RESET_PC + 32'd4);
        check("rst_out_instr", s_out_instr, NOP);
        check("rst_out_mis", {31'b0, s_out_mis}, 32'd0);

        // Free run, 1-cycle memory
        rst = 1'b0;
        exp_q.delete();
        exp_next = RESET_PC;
        first = -1;
        nv = 0;
        for (int k = 0; k < 22; k++) begin
            cycle();
            if (k == 0) begin
                check("first_req_valid", {31'b0, s_req_valid}, 32'd1);
                check("first_req_addr", s_req_addr, RESET_PC);
            end
            if (s_out_valid) begin
                if (first < 0) first = k;
                nv++;
            end
        end
        check("first_valid_cycle", 32'(first), 32'd2);
        check("throughput", 32'(nv), 32'd20);

        // Back-pressure
        stall_if = 1'b1;
        repeat (10) cycle();
        fill_exp();
        check("bp_req_drop", {31'b0, s_req_valid}, 32'd0);
        check("bp_out_valid", {31'b0, s_out_valid}, 32'd1);
        check("bp_hold_pc", s_out_pc, exp_q[0]);
        stall_if = 1'b0;
        repeat (20) cycle();

        // Bubble
        fill_exp();
        bexp = exp_q[0];
        bubble_if = 1'b1;
        cycle();
        check("bubble_valid", {31'b0, s_out_valid}, 32'd0);
        bubble_if = 1'b0;
        cycle();
        check("bubble_resume", {31'b0, s_out_valid}, 32'd1);
        check("bubble_same_pc", s_out_pc, bexp);

        // Wrap and redirect latency
        pc_src = 1'b1;
        new_pc = 32'hFFFF_FFFC;
        cycle();
        check("redir_no_req", {31'b0, s_req_valid}, 32'd0);
        pc_src = 1'b0;
        cycle();
        check("redir_req_valid", {31'b0, s_req_valid}, 32'd1);
        check("redir_req_addr", s_req_addr, 32'hFFFF_FFFC);
        cycle();
        check("wrap_req_valid", {31'b0, s_req_valid}, 32'd1);
        check("wrap_req_addr", s_req_addr, 32'h0000_0000);
        cycle();
        check("wrap_out_valid", {31'b0, s_out_valid}, 32'd1);
        check("wrap_out_pc", s_out_pc, 32'hFFFF_FFFC);
        check("wrap_out_pc4", s_out_pc4, 32'h0000_0000);
        repeat (10) cycle();

        // Redirect with stale responses in flight, together with stall
        lat = 3;
        for (int i = 0; i < 20 && mq_addr.size() < 3; i++) cycle();
        check("lat3_inflight", 32'(mq_addr.size() >= 3), 32'd1);
        pc_src = 1'b1;
        new_pc = 32'h0000_0100;
        stall_if = 1'b1;
        cycle();
        check("redir_stall_no_req", {31'b0, s_req_valid}, 32'd0);
        pc_src = 1'b0;
        stall_if = 1'b0;
        wait_first("lat3_first_pc", 32'h0000_0100);
        repeat (12) cycle();
        lat = 1;
        repeat (4) cycle();

`ifdef IF_MISALIGN_CHK_EN
        sb_en = 1'b0;
        pc_src = 1'b1;
        new_pc = 32'h0000_0102;
        cycle();
        pc_src = 1'b0;
        stall_if = 1'b1;
        seen = 0;
        req_seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            cycle();
            if (s_req_valid) req_seen = 1;
            if (s_out_valid) seen = 1;
        end
        check("mis_seen", 32'(seen), 32'd1);
        check("mis_pc", s_out_pc, 32'h0000_0102);
        check("mis_pc4", s_out_pc4, 32'h0000_0106);
        check("mis_instr", s_out_instr, NOP);
        check("mis_flag", {31'b0, s_out_mis}, 32'd1);
        stall_if = 1'b0;
        repeat (6) begin
            cycle();
            if (s_req_valid) req_seen = 1;
        end
        check("mis_no_req", 32'(req_seen), 32'd0);
        check("mis_popped", {31'b0, s_out_valid}, 32'd0);
        sb_en = 1'b1;
        pc_src = 1'b1;
        new_pc = 32'h0000_0200;
        cycle();
        pc_src = 1'b0;
        wait_first("mis_resume_pc", 32'h0000_0200);
        repeat (8) cycle();
`else
        pc_src = 1'b1;
        new_pc = 32'h0000_0102;
        cycle();
        pc_src = 1'b0;
        wait_first("align_force_pc", 32'h0000_0100);
        check("align_force_mis", {31'b0, s_out_mis}, 32'd0);
        repeat (8) cycle();
`endif

        // Random traffic
        lat = 0;
        rdy_rand = 1'b1;
        p0 = n_pops;
        for (int i = 0; i < 300; i++) begin
            stall_if  = ($urandom_range(0, 3) == 0);
            bubble_if = ($urandom_range(0, 7) == 0);
            pc_src    = ($urandom_range(0, 24) == 0);
            new_pc    = $urandom & 32'hFFFF_FFFC;
            cycle();
        end
        pc_src = 1'b0;
        stall_if = 1'b0;
        bubble_if = 1'b0;
        rdy_rand = 1'b0;
        repeat (15) cycle();
        check("rand_progress", 32'(n_pops > p0 + 50), 32'd1);

        // Mid-transaction reset
        lat = 3;
        repeat (6) cycle();
        rst = 1'b1;
        repeat (2) cycle();
        check("mrst_req_valid", {31'b0, s_req_valid}, 32'd0);
        check("mrst_out_valid", {31'b0, s_out_valid}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        exp_next = RESET_PC;
        lat = 1;
        p0 = n_pops;
        wait_first("mrst_first_pc", RESET_PC);
        repeat (10) cycle();
        check("mrst_progress", 32'(n_pops > p0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
